// File: rtl/rx_correlator_history_buffer.sv
// Multi-channel circular history buffer for correlator results: a triggered write
// sweep into a shared RAM plus a two-cycle pipelined age-indexed read port.
module rx_correlator_history_buffer #(
    parameter int N_CH  = 4,
    parameter int DW    = 33,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   crx_clk,
    input  logic                   rrx_rst,
    input  logic                   erx_en,
    input  logic                   inew_sample_trigger,
    input  logic [N_CH*DW-1:0]     isample_correlation,
    input  logic                   ifreeze,
    input  logic                   ird_req,
    input  logic [CW-1:0]          ird_channel,
    input  logic [AW-1:0]          ird_offset,
    output logic                   ord_valid,
    output logic signed [DW-1:0]   ord_data,
    output logic                   obusy,
    output logic [AW:0]            ofill,
    output logic                   ooverrun,
    output logic                   ofrozen
);

    typedef enum logic {IDLE, SWEEP} state_t;

    localparam logic [CW-1:0] LAST_K   = CW'(N_CH - 1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(DEPTH);

    state_t              state, state_next;
    logic [CW-1:0]       k, k_next;
    logic [AW-1:0]       wr_ptr;
    logic [N_CH*DW-1:0]  latched;
    logic                accept, wr_en, commit, drop;

    logic [DW-1:0]       mem [N_CH*DEPTH];
    logic                rd_stage;
    logic [CW+AW-1:0]    rd_addr;
    logic [AW-1:0]       rd_slot;

    assign obusy   = (state == SWEEP);
    assign rd_slot = wr_ptr - AW'(1) - ird_offset;

    always_comb begin
        state_next = state;
        k_next     = k;
        accept     = 1'b0;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        if (!erx_en) begin
            // disable aborts the sweep without committing the partial set
            state_next = IDLE;
            k_next     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inew_sample_trigger && !ifreeze) begin
                        accept     = 1'b1;
                        state_next = SWEEP;
                        k_next     = '0;
                    end
                end
                SWEEP: begin
                    wr_en = 1'b1;
                    drop  = inew_sample_trigger;
                    if (k == LAST_K) begin
                        commit     = 1'b1;
                        state_next = IDLE;
                        k_next     = '0;
                    end else begin
                        k_next = k + 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            state    <= IDLE;
            k        <= '0;
            wr_ptr   <= '0;
            ofill    <= '0;
            latched  <= '0;
            ooverrun <= 1'b0;
            ofrozen  <= 1'b0;
        end else begin
            state    <= state_next;
            k        <= k_next;
            ooverrun <= drop;
            ofrozen  <= ifreeze & ~obusy;
            if (accept) latched <= isample_correlation;
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (ofill != FILL_MAX) ofill <= ofill + 1'b1;
            end
        end
    end

    always_ff @(posedge crx_clk) begin
        if (wr_en) mem[{k, wr_ptr}] <= latched[k*DW +: DW];
    end

    // read-first: ord_data samples the pre-write word on an address collision
    always_ff @(posedge crx_clk or posedge rrx_rst) begin
        if (rrx_rst) begin
            rd_stage  <= 1'b0;
            rd_addr   <= '0;
            ord_valid <= 1'b0;
            ord_data  <= '0;
        end else begin
            rd_stage  <= ird_req & erx_en;
            ord_valid <= rd_stage;
            if (ird_req && erx_en) rd_addr <= {ird_channel, rd_slot};
            if (rd_stage) ord_data <= mem[rd_addr];
        end
    end

endmodule
